// File: rtl/ram_pkg.sv
// Shared constants, FSM encoding and helpers for the single-port byte-enable RAM.
package ram_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;
    localparam int unsigned RDW_NO_CHANGE   = 2;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_e;

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Delay line for read data plus its valid bit; data only advances with valid,
// so the output word holds between strobes.
module ram_rd_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_stages
            logic [STAGES-1:0] vld_q, vld_d;
            logic [WIDTH-1:0]  dat_q [STAGES];
            logic [WIDTH-1:0]  dat_d [STAGES];

            always_comb begin
                vld_d    = '0;
                vld_d[0] = in_valid;
                dat_d[0] = in_valid ? in_data : dat_q[0];
                for (int unsigned i = 1; i < STAGES; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        dat_q[i] <= dat_d[i];
                    end
                end
            end

            assign out_valid = vld_q[STAGES-1];
            assign out_data  = dat_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ram_sp_sr_sw_be.sv
// Single-port synchronous RAM: byte-enable writes, configurable read latency,
// selectable read-during-write behaviour and optional post-reset clear.
module ram_sp_sr_sw_be
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned RDW_MODE       = RDW_READ_FIRST,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cs,
    input  logic                              we,
    input  logic [be_width(DATA_WIDTH)-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]             address,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              rd_valid,
    output logic                              ready
);

    localparam int unsigned BW    = be_width(DATA_WIDTH);
    localparam int unsigned IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      clr_addr_q, clr_addr_d;
    logic                  ready_q, ready_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  acc;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [BW-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_INIT: begin
                clr_addr_d = '0;
                state_d    = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                if (clr_addr_q == IDX_W'(RAM_DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
        ready_d = (state_d == ST_READY);
    end

    assign idx      = address[IDX_W-1:0];
    assign in_range = (32'(address) < RAM_DEPTH);
    assign cur_word = mem[idx];

    // The clear sweep and user writes share one write port; they never overlap
    // because ready is low for the whole clear.
    always_comb begin
        acc     = cs && ready_q;
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = be;
        wr_data = wdata;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_addr_q;
            wr_be   = '1;
            wr_data = '0;
        end else if (acc && we && in_range) begin
            wr_en = 1'b1;
        end

        for (int unsigned i = 0; i < BW; i++) begin
            merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : cur_word[8*i +: 8];
        end

        if (!in_range) begin
            rd_word = '0;
        end else if (we && (RDW_MODE == RDW_WRITE_FIRST)) begin
            rd_word = merged;
        end else begin
            rd_word = cur_word;
        end

        rd_vld_d  = acc && (!we || (RDW_MODE != RDW_NO_CHANGE));
        rd_data_d = rd_vld_d ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BW; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    ram_rd_pipe #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_vld_q),
        .in_data   (rd_data_q),
        .out_valid (rd_valid),
        .out_data  (rdata)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_ram_sp_sr_sw_be.sv
// Directed bench: four RAM instances covering latency 1..3, all read-during-write
// modes, clear/no-clear, and an out-of-range address window.
module tb_ram_sp_sr_sw_be;

    logic        clk;
    logic        rst;
    logic        cs       [4];
    logic        we       [4];
    logic [3:0]  be       [4];
    logic [8:0]  addr     [4];
    logic [31:0] wdata    [4];
    logic [31:0] rdata    [4];
    logic        rd_valid [4];
    logic        ready    [4];

    int checks;
    int errors;

    // A: latency 3, read-first, clear, 16 words
    ram_sp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .RAM_DEPTH(16), .READ_LATENCY(3),
                      .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(rst), .cs(cs[0]), .we(we[0]), .be(be[0]), .address(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .rd_valid(rd_valid[0]), .ready(ready[0]));
    // B: latency 1, write-first, no clear
    ram_sp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .RAM_DEPTH(16), .READ_LATENCY(1),
                      .RDW_MODE(1), .CLEAR_ON_RESET(0)) u_b (
        .clk(clk), .rst(rst), .cs(cs[1]), .we(we[1]), .be(be[1]), .address(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .rd_valid(rd_valid[1]), .ready(ready[1]));
    // C: latency 2, no-change, clear
    ram_sp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .RAM_DEPTH(16), .READ_LATENCY(2),
                      .RDW_MODE(2), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .rst(rst), .cs(cs[2]), .we(we[2]), .be(be[2]), .address(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .rd_valid(rd_valid[2]), .ready(ready[2]));
    // D: 256 words behind a 9-bit address
    ram_sp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .RAM_DEPTH(256), .READ_LATENCY(1),
                      .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_d (
        .clk(clk), .rst(rst), .cs(cs[3]), .we(we[3]), .be(be[3]), .address(addr[3]),
        .wdata(wdata[3]), .rdata(rdata[3]), .rd_valid(rd_valid[3]), .ready(ready[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned i, input logic c, input logic w, input logic [3:0] b,
                         input logic [8:0] a, input logic [31:0] d);
        cs[i]    = c;
        we[i]    = w;
        be[i]    = b;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    task automatic idle(input int unsigned i);
        drive(i, 1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int unsigned i = 0; i < 4; i++) idle(i);
        tick; tick; tick;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdata[i] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d] got %h exp 0", i, rdata[i]); end
            checks++;
            if (rd_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_rd_valid[%0d] got %b exp 0", i, rd_valid[i]); end
            checks++;
            if (ready[i] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got %b exp 0", i, ready[i]); end
        end
    endtask

    // One INIT edge after release, then RAM_DEPTH clear cycles before ready.
    task automatic test_clear;
        rst = 1'b0;
        tick;
        checks++;
        if (ready[1] !== 1'b1) begin errors++; $display("FAIL noclear_ready got %b exp 1", ready[1]); end
        for (int k = 1; k <= 16; k++) begin
            tick;
            checks++;
            if (ready[0] !== (k == 16)) begin errors++; $display("FAIL clear_ready_a k=%0d got %b exp %b", k, ready[0], k == 16); end
            checks++;
            if (ready[2] !== (k == 16)) begin errors++; $display("FAIL clear_ready_c k=%0d got %b exp %b", k, ready[2], k == 16); end
        end
    endtask

    task automatic test_byte_enable;
        drive(0, 1, 1, 4'b1111, 9'd5, 32'hAABBCCDD); tick;
        drive(0, 1, 1, 4'b0101, 9'd5, 32'h11223344); tick;
        drive(0, 1, 0, 4'b0000, 9'd5, 32'h0);        tick;
        idle(0);
        checks++;
        if (rd_valid[0] !== 1'b1 || rdata[0] !== 32'h0) begin errors++; $display("FAIL be_rf1 got v=%b d=%h exp v=1 d=0", rd_valid[0], rdata[0]); end
        tick;
        checks++;
        if (rd_valid[0] !== 1'b1 || rdata[0] !== 32'hAABBCCDD) begin errors++; $display("FAIL be_rf2 got v=%b d=%h exp v=1 d=aabbccdd", rd_valid[0], rdata[0]); end
        tick;
        checks++;
        if (rd_valid[0] !== 1'b1 || rdata[0] !== 32'hAA22CC44) begin errors++; $display("FAIL be_read got v=%b d=%h exp v=1 d=aa22cc44", rd_valid[0], rdata[0]); end
        tick;
        checks++;
        if (rd_valid[0] !== 1'b0 || rdata[0] !== 32'hAA22CC44) begin errors++; $display("FAIL be_hold got v=%b d=%h exp v=0 d=aa22cc44", rd_valid[0], rdata[0]); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, 4'hF, 9'(i), 32'hC0DE0000 + 32'(i));
            tick;
        end
        idle(0);
        tick; tick; tick; tick;
        for (int n = 0; n < 12; n++) begin
            if (n < 8) drive(0, 1, 0, 4'h0, 9'(n), 32'h0);
            else       idle(0);
            tick;
            checks++;
            if (rd_valid[0] !== (n >= 2 && n < 10)) begin errors++; $display("FAIL b2b_valid n=%0d got %b exp %b", n, rd_valid[0], n >= 2 && n < 10); end
            if (n >= 2 && n < 10) begin
                checks++;
                if (rdata[0] !== 32'hC0DE0000 + 32'(n - 2)) begin errors++; $display("FAIL b2b_data n=%0d got %h exp %h", n, rdata[0], 32'hC0DE0000 + 32'(n - 2)); end
            end
        end
    endtask

    task automatic test_rdw;
        // READ_FIRST, latency 3
        drive(0, 1, 1, 4'hF, 9'd3, 32'h1); tick; idle(0); tick; tick; tick;
        drive(0, 1, 1, 4'h1, 9'd3, 32'hFF); tick; idle(0); tick; tick;
        checks++;
        if (rd_valid[0] !== 1'b1 || rdata[0] !== 32'h1) begin errors++; $display("FAIL rdw_rf got v=%b d=%h exp v=1 d=1", rd_valid[0], rdata[0]); end
        tick;
        checks++;
        if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL rdw_rf_strobe got %b exp 0", rd_valid[0]); end
        drive(0, 1, 0, 4'h0, 9'd3, 32'h0); tick; idle(0); tick; tick;
        checks++;
        if (rd_valid[0] !== 1'b1 || rdata[0] !== 32'hFF) begin errors++; $display("FAIL rdw_rf_after got v=%b d=%h exp v=1 d=ff", rd_valid[0], rdata[0]); end

        // WRITE_FIRST, latency 1
        drive(1, 1, 1, 4'hF, 9'd3, 32'h1); tick;
        checks++;
        if (rd_valid[1] !== 1'b1 || rdata[1] !== 32'h1) begin errors++; $display("FAIL rdw_wf_init got v=%b d=%h exp v=1 d=1", rd_valid[1], rdata[1]); end
        drive(1, 1, 1, 4'h1, 9'd3, 32'hFF); tick;
        checks++;
        if (rd_valid[1] !== 1'b1 || rdata[1] !== 32'hFF) begin errors++; $display("FAIL rdw_wf got v=%b d=%h exp v=1 d=ff", rd_valid[1], rdata[1]); end
        drive(1, 1, 1, 4'hC, 9'd3, 32'h12345678); tick;
        checks++;
        if (rd_valid[1] !== 1'b1 || rdata[1] !== 32'h123400FF) begin errors++; $display("FAIL rdw_wf_merge got v=%b d=%h exp v=1 d=123400ff", rd_valid[1], rdata[1]); end
        drive(1, 1, 1, 4'hF, 9'd7, 32'h0BADF00D); tick; idle(1);
        checks++;
        if (rd_valid[1] !== 1'b1 || rdata[1] !== 32'h0BADF00D) begin errors++; $display("FAIL rdw_wf_addr7 got v=%b d=%h exp v=1 d=0badf00d", rd_valid[1], rdata[1]); end
        tick;
        checks++;
        if (rd_valid[1] !== 1'b0) begin errors++; $display("FAIL rdw_wf_strobe got %b exp 0", rd_valid[1]); end

        // NO_CHANGE, latency 2
        drive(2, 1, 1, 4'hF, 9'd3, 32'h1); tick; idle(2); tick;
        checks++;
        if (rd_valid[2] !== 1'b0) begin errors++; $display("FAIL rdw_nc_init got v=%b exp 0", rd_valid[2]); end
        drive(2, 1, 0, 4'h0, 9'd3, 32'h0); tick; idle(2); tick;
        checks++;
        if (rd_valid[2] !== 1'b1 || rdata[2] !== 32'h1) begin errors++; $display("FAIL rdw_nc_read got v=%b d=%h exp v=1 d=1", rd_valid[2], rdata[2]); end
        drive(2, 1, 1, 4'h1, 9'd3, 32'hFF); tick; idle(2); tick;
        checks++;
        if (rd_valid[2] !== 1'b0 || rdata[2] !== 32'h1) begin errors++; $display("FAIL rdw_nc got v=%b d=%h exp v=0 d=1", rd_valid[2], rdata[2]); end
        tick;
        checks++;
        if (rd_valid[2] !== 1'b0 || rdata[2] !== 32'h1) begin errors++; $display("FAIL rdw_nc_late got v=%b d=%h exp v=0 d=1", rd_valid[2], rdata[2]); end
        drive(2, 1, 0, 4'h0, 9'd3, 32'h0); tick; idle(2); tick;
        checks++;
        if (rd_valid[2] !== 1'b1 || rdata[2] !== 32'hFF) begin errors++; $display("FAIL rdw_nc_after got v=%b d=%h exp v=1 d=ff", rd_valid[2], rdata[2]); end
    endtask

    task automatic test_mid_clear;
        rst = 1'b1;
        drive(1, 1, 1, 4'hF, 9'd7, 32'hDEADBEEF);
        #1;
        checks++;
        if (rdata[0] !== 32'h0 || rd_valid[0] !== 1'b0) begin errors++; $display("FAIL async_rdata_a got v=%b d=%h exp v=0 d=0", rd_valid[0], rdata[0]); end
        checks++;
        if (ready[1] !== 1'b0 || rdata[1] !== 32'h0) begin errors++; $display("FAIL async_b got rdy=%b d=%h exp rdy=0 d=0", ready[1], rdata[1]); end
        tick; tick;
        rst = 1'b0;
        tick;
        checks++;
        if (rd_valid[1] !== 1'b0 || ready[1] !== 1'b1) begin errors++; $display("FAIL gate_not_ready got v=%b rdy=%b exp v=0 rdy=1", rd_valid[1], ready[1]); end
        idle(1);
        for (int k = 0; k < 7; k++) tick;
        rst = 1'b1;
        #1;
        checks++;
        if (ready[0] !== 1'b0 || rd_valid[0] !== 1'b0 || rdata[0] !== 32'h0) begin errors++; $display("FAIL midclear_async got rdy=%b v=%b d=%h exp 0 0 0", ready[0], rd_valid[0], rdata[0]); end
        checks++;
        if (ready[1] !== 1'b0) begin errors++; $display("FAIL midclear_async_b got rdy=%b exp 0", ready[1]); end
        tick;
        rst = 1'b0;
        tick;
        for (int k = 1; k <= 16; k++) begin
            tick;
            checks++;
            if (ready[0] !== (k == 16)) begin errors++; $display("FAIL reclear_ready k=%0d got %b exp %b", k, ready[0], k == 16); end
        end
        drive(1, 1, 0, 4'h0, 9'd7, 32'h0); tick; idle(1);
        checks++;
        if (rd_valid[1] !== 1'b1 || rdata[1] !== 32'h0BADF00D) begin errors++; $display("FAIL gate_no_write got v=%b d=%h exp v=1 d=0badf00d", rd_valid[1], rdata[1]); end
        for (int n = 0; n < 18; n++) begin
            if (n < 16) drive(0, 1, 0, 4'h0, 9'(n), 32'h0);
            else        idle(0);
            tick;
            if (n >= 2) begin
                checks++;
                if (rd_valid[0] !== 1'b1 || rdata[0] !== 32'h0) begin errors++; $display("FAIL reclear_zero a=%0d got v=%b d=%h exp v=1 d=0", n - 2, rd_valid[0], rdata[0]); end
            end
        end
    endtask

    task automatic test_out_of_range;
        for (int k = 0; k < 600 && ready[3] !== 1'b1; k++) tick;
        checks++;
        if (ready[3] !== 1'b1) begin errors++; $display("FAIL d_ready_timeout got %b exp 1", ready[3]); end
        drive(3, 1, 1, 4'hF, 9'd10, 32'h55); tick;
        checks++;
        if (rd_valid[3] !== 1'b1 || rdata[3] !== 32'h0) begin errors++; $display("FAIL oor_w10 got v=%b d=%h exp v=1 d=0", rd_valid[3], rdata[3]); end
        drive(3, 1, 0, 4'h0, 9'd10, 32'h0); tick;
        checks++;
        if (rd_valid[3] !== 1'b1 || rdata[3] !== 32'h55) begin errors++; $display("FAIL oor_r10 got v=%b d=%h exp v=1 d=55", rd_valid[3], rdata[3]); end
        drive(3, 1, 1, 4'hF, 9'd300, 32'hCAFEF00D); tick;
        checks++;
        if (rd_valid[3] !== 1'b1 || rdata[3] !== 32'h0) begin errors++; $display("FAIL oor_w300 got v=%b d=%h exp v=1 d=0", rd_valid[3], rdata[3]); end
        drive(3, 1, 0, 4'h0, 9'd300, 32'h0); tick;
        checks++;
        if (rd_valid[3] !== 1'b1 || rdata[3] !== 32'h0) begin errors++; $display("FAIL oor_r300 got v=%b d=%h exp v=1 d=0", rd_valid[3], rdata[3]); end
        drive(3, 1, 0, 4'h0, 9'd44, 32'h0); tick; idle(3);
        checks++;
        if (rd_valid[3] !== 1'b1 || rdata[3] !== 32'h0) begin errors++; $display("FAIL oor_alias44 got v=%b d=%h exp v=1 d=0", rd_valid[3], rdata[3]); end
        tick;
        checks++;
        if (rd_valid[3] !== 1'b0) begin errors++; $display("FAIL oor_strobe got %b exp 0", rd_valid[3]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_clear;
        test_byte_enable;
        test_back_to_back;
        test_rdw;
        test_mid_clear;
        test_out_of_range;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sp_sr_sw_be.md
Name: ram_sp_sr_sw_be

Overview:
Parametrised single-port synchronous RAM with the following features:
- separate write-data and read-data buses;
- per-byte write enables;
- configurable read latency;
- selectable read-during-write behaviour;
- optional hardware clear of the whole array after reset.

It is the general-purpose on-chip storage block for buffers and lookup tables. It reports read data with a valid strobe, and it reports when it is ready to accept accesses.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address width.
RAM_DEPTH, 1 << ADDR_WIDTH, number of words; must be ≤ 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 to 3.
RDW_MODE, 0, read-during-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
CLEAR_ON_RESET, 1, 1 = zero the entire array after reset before setting ready.

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  reset, asynchronous, active-high
cs  input  1  chip select; an access is accepted when cs && ready
we  input  1  1 = write, 0 = read
be  input  DATA_WIDTH/8  byte enables; used for writes only
address  input  ADDR_WIDTH  word address
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  read data; meaningful while rd_valid is high
rd_valid  output  1  one-cycle strobe per returned word
ready  output  1  1 = block accepts accesses

Behaviour:
- Reset (rst high, asynchronous):
  - rdata = 0, rd_valid = 0, ready = 0.
  - Read pipeline flushed.
  - FSM state = INIT; clear counter = 0.
  - Array contents are not reset by rst itself.
- FSM states: INIT -> CLEAR -> READY.
  - INIT -> CLEAR on the first clk edge after rst falls, if CLEAR_ON_RESET = 1.
  - INIT -> READY on that same edge, if CLEAR_ON_RESET = 0.
  - CLEAR: writes 0 to word clr_addr each cycle, clr_addr 0 .. RAM_DEPTH-1. After the last word, goes to READY; the clear takes RAM_DEPTH cycles.
  - READY: ready = 1 (registered). The FSM stays in READY until rst.
- rst asserted during CLEAR: the clear aborts immediately. After release it restarts from address 0.
- Accesses while ready = 0 are ignored: no write, and no rd_valid.
- Write (cs && we && ready):
  - For each byte i with be[i] = 1: mem[address][8i+7:8i] <= wdata[8i+7:8i].
  - Bytes with be[i] = 0 are unchanged.
  - be = 0 means no array change.
- Read (cs && !we && ready): rd_valid = 1 exactly READ_LATENCY cycles after the accepting edge, with rdata = mem[address] as of that edge.
- Back-to-back accesses: one access is accepted per cycle with no bubbles. Results return in order.
- Read-during-write, for a write cycle:
  - READ_FIRST: produces a read result equal to the old word (before the write).
  - WRITE_FIRST: produces a read result equal to the merged new word; unwritten bytes hold their old values.
  - NO_CHANGE: produces no rd_valid, and rdata is unchanged.
- rdata holds its last value between rd_valid pulses. It is 0 after reset until the first result.
- Address ≥ RAM_DEPTH: writes are ignored. Reads return 0, with rd_valid still asserted.
- Read pipeline: READ_LATENCY-1 register stages follow the array output register. The valid bit travels alongside the data.

Decomposition:
- Package ram_pkg holds:
  - constants RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1, RDW_NO_CHANGE = 2;
  - FSM state encoding ST_INIT, ST_CLEAR, ST_READY;
  - function be_width(DATA_WIDTH) = DATA_WIDTH/8.
- Sub-module ram_rd_pipe carries data plus valid through a parametrised delay.
  - Parameters: WIDTH, STAGES (0 to 2).
  - Reset behaviour: asynchronous clear to 0.
  - Instantiated once, after the array read register.

Test Plan:
1. Reset clear, DEPTH=16, CLEAR_ON_RESET=1: release rst -> ready rises after exactly 16 cycles; subsequent reads of addresses 0..15 all return 0.
2. Byte-enable write, DATA_WIDTH=32: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read addr 5 returns 0xAA22CC44.
3. Latency and throughput, READ_LATENCY=3: write then read addresses 0..7 back to back -> rd_valid pulses start 3 cycles after the first read, 8 consecutive cycles, data in order.
4. Read-during-write at addr 3 holding 0x00000001, writing 0x000000FF with be=4'b0001:
   - READ_FIRST returns 0x00000001;
   - WRITE_FIRST returns 0x000000FF;
   - NO_CHANGE gives no rd_valid and rdata unchanged.
5. Reset mid-clear, DEPTH=16: assert rst at clear cycle 7 -> rdata=0, rd_valid=0, ready=0 asynchronously; after release, ready rises after 16 more cycles.
6. Gating:
   - cs with ready=0 -> no write, no rd_valid;
   - address 300 with DEPTH=256 -> write ignored, read returns 0 with rd_valid.
